// File: rtl/pe_opsum_collector.sv
// ---------------------------------------------------------------------------
// pe_opsum_collector
//
// Drains a PE's output-psum FIFO and writes every 64-bit packed opsum word
// (four 16-bit psums) to a result-buffer write port at consecutive addresses.
// A one-cycle configure pulse carries the layer shape (F, n, p) and the first
// write address. The block then collects (p*n*F)/4 words and pulses done.
// Any remainder from that division is never collected.
//
// Each word takes four states:
//   ARMED -> POP -> GAP -> WRITE
// POP consumes the head of a first-word-fall-through FIFO. GAP gives the
// FIFO one cycle to update its empty flag and head, so the same entry is
// never popped twice. WRITE holds the request until the buffer accepts it.
//
// Ports
//   clk               clock; all state changes on the rising edge
//   reset             asynchronous active-low reset
//   configure         one-cycle pulse: latch shape and base_addr, arm/restart
//   F, n, p           ofmap row width, batch count, filters per PE
//   base_addr         first result-buffer write address
//   busy              high in ARMED, POP, GAP and WRITE
//   done              one-cycle pulse after the last word is written
//   opsum             FIFO head; valid while opsum_fifo_empty is low
//   opsum_fifo_empty  FIFO empty flag
//   pop_opsum         consumes the FIFO head in the cycle it is high
//   wr_en             result-buffer write request
//   wr_addr           write address, base_addr + word index (wraps)
//   wr_data           captured opsum word
//   wr_ready          buffer accepts the write when wr_en && wr_ready
//   word_count        words written since the last configure
// ---------------------------------------------------------------------------
module pe_opsum_collector #(
    parameter int DATA_WIDTH_PSUM = 64,
    parameter int F_WIDTH         = 6,
    parameter int n_WIDTH         = 3,
    parameter int p_WIDTH         = 5,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 configure,
    input  logic [F_WIDTH-1:0]                   F,
    input  logic [n_WIDTH-1:0]                   n,
    input  logic [p_WIDTH-1:0]                   p,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    output logic                                 busy,
    output logic                                 done,
    input  logic [DATA_WIDTH_PSUM-1:0]           opsum,
    input  logic                                 opsum_fifo_empty,
    output logic                                 pop_opsum,
    output logic                                 wr_en,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic [DATA_WIDTH_PSUM-1:0]           wr_data,
    input  logic                                 wr_ready,
    output logic [p_WIDTH+n_WIDTH+F_WIDTH-1:0]   word_count
);

    // The product p*n*F needs at most p_WIDTH+n_WIDTH+F_WIDTH bits.
    // The word count and the total use that same width.
    localparam int CNT_WIDTH = p_WIDTH + n_WIDTH + F_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_POP,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [CNT_WIDTH-1:0]        count_q;
    logic [CNT_WIDTH-1:0]        total_q;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [DATA_WIDTH_PSUM-1:0]  data_q;

    logic [CNT_WIDTH-1:0]        product;
    logic [CNT_WIDTH-1:0]        total_d;
    logic                        write_accepted;

    // The product is formed at full width before the divide-by-four.
    // Truncation therefore only drops the partial last word, never high bits.
    // The job length is the only thing later states need from F, n and p,
    // so only the total is stored.
    assign product = CNT_WIDTH'(p) * CNT_WIDTH'(n) * CNT_WIDTH'(F);
    assign total_d = product >> 2;

    assign write_accepted = (state_q == S_WRITE) && wr_ready;

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        pop_opsum = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end

            S_ARMED: begin
                busy = 1'b1;
                // The count is checked before the FIFO.
                // A zero-length job therefore completes without ever popping.
                if (count_q == total_q) begin
                    state_d = S_DONE;
                end else if (!opsum_fifo_empty) begin
                    state_d = S_POP;
                end
            end

            S_POP: begin
                busy      = 1'b1;
                pop_opsum = 1'b1;
                state_d   = S_GAP;
            end

            S_GAP: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) begin
                    state_d = S_ARMED;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // configure restarts the job from any state.
        // A word captured but not yet written is dropped.
        // In the DONE cycle done still pulses, and the next job starts at once.
        if (configure) begin
            state_d = S_ARMED;
        end
    end

    // -----------------------------------------------------------------------
    // State, job parameters, word counter and captured data
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data register is reset as well.
            // wr_data must read zero out of reset, not whatever the flops
            // powered up with.
            state_q <= S_IDLE;
            count_q <= '0;
            total_q <= '0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout.
            // Every register samples the pre-edge values of the others.
            state_q <= state_d;

            if (configure) begin
                count_q <= '0;
                total_q <= total_d;
                base_q  <= base_addr;
            end else if (write_accepted) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end

            // The FIFO is first-word fall-through.
            // The head is valid in the same cycle as the pop that consumes it.
            if (state_q == S_POP) begin
                data_q <= opsum;
            end
        end
    end

    // The address is base + index modulo 2^ADDR_WIDTH.
    // Wrapping past the top of the buffer is intended.
    assign wr_addr    = base_q + ADDR_WIDTH'(count_q);
    assign wr_data    = data_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_pe_opsum_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_opsum_collector
//
// Self-checking bench for pe_opsum_collector.
//
// A queue-based FIFO model feeds opsum words, and a driver process shapes
// wr_ready. When a job is configured, the bench computes the expected writes
// from the job shape: (p*n*F)/4 words, address base+i modulo 1024, and data
// equal to the i-th word the FIFO supplies. These writes go into a
// scoreboard queue. A negedge monitor pops the queue on every accepted write.
// The monitor also checks:
//   - pop/empty legality and pop spacing
//   - stall stability of wr_en, wr_addr and wr_data
//   - that busy is low at done
// ---------------------------------------------------------------------------
module tb_pe_opsum_collector;

    localparam int DW = 64;
    localparam int FW = 6;
    localparam int NW = 3;
    localparam int PW = 5;
    localparam int AW = 10;
    localparam int CW = FW + NW + PW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // DUT connections
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          configure = 1'b0;
    logic [FW-1:0] F = '0;
    logic [NW-1:0] n = '0;
    logic [PW-1:0] p = '0;
    logic [AW-1:0] base_addr = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] opsum = '0;
    logic          opsum_fifo_empty = 1'b1;
    logic          pop_opsum;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready = 1'b1;
    logic [CW-1:0] word_count;

    // Bookkeeping
    int            total_checks = 0;
    int            bad = 0;
    int            cyc = 0;

    // Scoreboard
    wr_t           exp_q[$];
    wr_t           e;

    // FIFO and ready models
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] job_data = '0;
    int            supplied = 0;
    int            supply_limit = 0;
    int            fifo_mode = 0;   // 0 keep full, 1 toggle empty, 2 random
    int            ready_mode = 0;  // 0 always, 1 backpressure, 2 random, 3 never
    int            stall_left = 0;
    int            bp_trig = -1;
    bit            pop_seen = 1'b0;
    bit            push_now;

    // Monitor statistics
    int            pops = 0;
    int            writes = 0;
    int            dones = 0;
    int            last_write_cyc = 0;
    int            done_cyc = 0;
    int            last_pop_cyc = -100;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    pe_opsum_collector #(
        .DATA_WIDTH_PSUM (DW),
        .F_WIDTH         (FW),
        .n_WIDTH         (NW),
        .p_WIDTH         (PW),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .configure        (configure),
        .F                (F),
        .n                (n),
        .p                (p),
        .base_addr        (base_addr),
        .busy             (busy),
        .done             (done),
        .opsum            (opsum),
        .opsum_fifo_empty (opsum_fifo_empty),
        .pop_opsum        (pop_opsum),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .word_count       (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh_fifo();
        opsum            = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        opsum_fifo_empty = (fifo_q.size() == 0);
    endtask

    // -----------------------------------------------------------------------
    // FIFO / wr_ready driver. Inputs change 1 time unit after the rising edge.
    // -----------------------------------------------------------------------
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pop_seen) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_seen = 1'b0;
        end
        if (supplied < supply_limit) begin
            case (fifo_mode)
                0:       push_now = (fifo_q.size() < 4);
                1:       push_now = (((cyc / 3) % 2) == 0) && (fifo_q.size() == 0);
                default: push_now = ($urandom_range(0, 2) == 0);
            endcase
            if (push_now) begin
                fifo_q.push_back(job_data + DW'(supplied));
                supplied++;
            end
        end
        refresh_fifo();
        case (ready_mode)
            0: wr_ready = 1'b1;
            1: begin
                if ((writes % 3) == 2 && writes != bp_trig) begin
                    bp_trig    = writes;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
            end
            2:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (pop_opsum) begin
                check("pop_while_empty", opsum_fifo_empty, 1'b0);
                check("pop_spacing_ge4", 64'((cyc - last_pop_cyc) >= 4), 64'd1);
                pops++;
                last_pop_cyc = cyc;
                pop_seen     = 1'b1;
            end
            if (wr_en) begin
                if (prev_stall) begin
                    check("stall_addr_stable", wr_addr, prev_addr);
                    check("stall_data_stable", wr_data, prev_data);
                end
                if (wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                    end
                    writes++;
                    last_write_cyc = cyc;
                end
            end
            prev_stall = wr_en && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            if (done) begin
                dones++;
                done_cyc = cyc;
                check("busy_low_at_done", busy, 1'b0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_pop"},        pop_opsum,  0);
        check({tag, "_wr_en"},      wr_en,      0);
        check({tag, "_wr_addr"},    wr_addr,    0);
        check({tag, "_wr_data"},    wr_data,    0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    // Set up the FIFO and the scoreboard, then issue a configure pulse.
    task automatic start_job(input int f_v, input int n_v, input int p_v, input int b,
                             input logic [63:0] d0, input int fm, input int rm,
                             input int supply, output int t, output int cfg_cyc);
        t = (p_v * n_v * f_v) / 4;
        @(posedge clk);
        #2;
        fifo_q.delete();
        supplied     = 0;
        supply_limit = supply;
        job_data     = d0;
        fifo_mode    = fm;
        ready_mode   = rm;
        bp_trig      = -1;
        stall_left   = 0;
        refresh_fifo();
        exp_q.delete();
        for (int i = 0; i < t; i++) begin
            exp_q.push_back('{addr: AW'((b + i) % 1024), data: d0 + DW'(i)});
        end
        pops      = 0;
        writes    = 0;
        dones     = 0;
        F         = FW'(f_v);
        n         = NW'(n_v);
        p         = PW'(p_v);
        base_addr = AW'(b);
        configure = 1'b1;
        cfg_cyc   = cyc;
        @(posedge clk);
        #2;
        configure = 1'b0;
        @(negedge clk);
        check("busy_after_cfg", busy, 1'b1);
        check("count_cleared", word_count, 0);
    endtask

    task automatic finish_job(input int t, input int cfg_cyc);
        int budget;
        for (budget = 0; budget < 20000 && dones == 0; budget++) @(negedge clk);
        repeat (3) @(negedge clk);
        if (dones == 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("done_count", dones, 1);
            check("word_count_final", word_count, t);
            check("pop_count", pops, t);
            check("write_count", writes, t);
            check("scoreboard_left", exp_q.size(), 0);
            check("busy_after_done", busy, 1'b0);
            if (t == 0) check("done_latency_zero", done_cyc - cfg_cyc, 2);
            else        check("done_latency", done_cyc - last_write_cyc, 2);
        end
    endtask

    task automatic run_job(input int f_v, input int n_v, input int p_v, input int b,
                           input logic [63:0] d0, input int fm, input int rm, input int supply);
        int t;
        int cfg_cyc;
        start_job(f_v, n_v, p_v, b, d0, fm, rm, supply, t, cfg_cyc);
        finish_job(t, cfg_cyc);
    endtask

    task automatic wait_for_write();
        int k;
        for (k = 0; k < 500 && !wr_en; k++) @(negedge clk);
        check("reached_write", wr_en, 1'b1);
    endtask

    initial begin
        int t;
        int cfg_cyc;
        logic [63:0] base_word;
        base_word = 64'h0001_0002_0003_0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b1;

        // Basic drain, empty stalls, backpressure
        run_job(55, 1, 16, 0, base_word, 0, 0, 220);
        run_job(55, 1, 16, 0, base_word, 1, 0, 220);
        run_job(55, 1, 16, 0, base_word, 0, 1, 220);

        // Truncation to zero, single word, address wrap
        run_job(3, 1, 1, 37, base_word, 0, 0, 3);
        run_job(5, 1, 1, 5, {$urandom, $urandom}, 0, 0, 5);
        run_job(8, 1, 4, 1020, {$urandom, $urandom}, 0, 0, 8);

        // Randomised shapes and handshakes
        for (int j = 0; j < 4; j++) begin
            int rf;
            int rn;
            int rp;
            rf = $urandom_range(1, 20);
            rn = $urandom_range(1, 3);
            rp = $urandom_range(1, 8);
            run_job(rf, rn, rp, $urandom_range(0, 1023), {$urandom, $urandom}, 2, 2, rf * rn * rp);
        end

        // Reset asserted mid-WRITE: outputs clear at once and no done follows
        start_job(20, 1, 4, 300, {$urandom, $urandom}, 0, 3, 20, t, cfg_cyc);
        wait_for_write();
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(posedge clk);
        #2;
        fifo_q.delete();
        supply_limit = 0;
        ready_mode   = 0;
        exp_q.delete();
        refresh_fifo();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", dones, 0);
        check("idle_after_reset", busy, 1'b0);

        // configure mid-job: the count restarts and the first write goes to 100
        start_job(20, 1, 4, 500, {$urandom, $urandom}, 0, 3, 20, t, cfg_cyc);
        wait_for_write();
        start_job(16, 2, 5, 100, {$urandom, $urandom}, 0, 0, 40, t, cfg_cyc);
        check("abort_wr_en_dropped", wr_en, 1'b0);
        finish_job(t, cfg_cyc);

        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
